// File: rtl/digest_hex_tx.sv
// digest_hex_tx: prints a latched digest as lowercase ASCII hex over the
// usart byte handshake, most-significant nibble first, optionally ending in CR LF.
module digest_hex_tx #(
  parameter int NIBBLES     = 32,
  parameter int APPEND_CRLF = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4*NIBBLES-1:0] digest,
  input  logic                 digest_valid,
  output logic                 ready,
  output logic                 done,
  output logic [7:0]           bytetosend,
  output logic                 send,
  input  logic                 sent
);

  localparam int TOTAL = NIBBLES + 2 * APPEND_CRLF;
  localparam logic [5:0] LAST = 6'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [4*NIBBLES-1:0] dig_q, dig_d;
  logic [5:0]           idx_q, idx_d;
  logic [7:0]           byte_q, byte_d;

  function automatic logic [7:0] hex_char(
    input logic [3:0] n
  );
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h57 + {4'h0, n};
  endfunction

  function automatic logic [7:0] char_at(
    input logic [4*NIBBLES-1:0] d,
    input logic [5:0]           i
  );
    logic [3:0] nib;
    if (int'(i) < NIBBLES) begin
      nib = 4'(d >> (4 * (NIBBLES - 1 - int'(i))));
      return hex_char(nib);
    end
    if (int'(i) == NIBBLES) return 8'h0d;
    return 8'h0a;
  endfunction

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    ready   = 1'b0;
    send    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (digest_valid) begin
          dig_d   = digest;
          idx_d   = 6'd0;
          byte_d  = char_at(digest, 6'd0);
          state_d = SEND;
        end
      end
      // send only while the usart reports idle, else its bit timer restarts
      SEND: begin
        if (sent) begin
          send    = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!sent) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (sent) begin
          if (idx_q == LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 6'd1;
            byte_d  = char_at(dig_q, idx_q + 6'd1);
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dig_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
    end
  end

  assign bytetosend = byte_q;

endmodule

// File: tb/tb_digest_hex_tx.sv
// tb_digest_hex_tx: two instances (with and without CR LF) driven together,
// each paced by a behavioural usart model; streams checked against hex strings.
module tb_digest_hex_tx;

  localparam int FRAME = 44;

  typedef struct packed {
    logic [3:0] nib;
    logic [7:0] ch;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         digest_valid = 1'b0;
  logic         hold = 1'b0;
  logic [127:0] digest = '0;

  logic [7:0] bts [2];
  logic       snd [2];
  logic       snt [2];
  logic       rdy [2];
  logic       dn [2];

  logic       idle [2] = '{1'b1, 1'b1};
  int         cnt [2] = '{0, 0};
  logic [7:0] held [2] = '{8'h00, 8'h00};
  int         stab_err [2] = '{0, 0};
  int         proto_err [2] = '{0, 0};
  int         dcnt [2] = '{0, 0};
  int         gap [2] = '{0, 0};
  int         last_done [2] = '{0, 0};
  int         cyc = 0;

  logic [7:0] cap [2][$];
  logic [7:0] exp_q [2][$];

  int n_cmp = 0;
  int n_err = 0;

  vec_t tbl [16];

  always #5 clock = ~clock;

  assign snt[0] = idle[0] & ~hold;
  assign snt[1] = idle[1] & ~hold;

  digest_hex_tx #(.NIBBLES(32), .APPEND_CRLF(1)) u0 (
    .clock(clock), .reset(reset),
    .digest(digest), .digest_valid(digest_valid),
    .ready(rdy[0]), .done(dn[0]),
    .bytetosend(bts[0]), .send(snd[0]), .sent(snt[0])
  );

  digest_hex_tx #(.NIBBLES(32), .APPEND_CRLF(0)) u1 (
    .clock(clock), .reset(reset),
    .digest(digest), .digest_valid(digest_valid),
    .ready(rdy[1]), .done(dn[1]),
    .bytetosend(bts[1]), .send(snd[1]), .sent(snt[1])
  );

  // usart model: idle drops one cycle after send, returns after FRAME cycles
  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        idle[k] <= 1'b1;
        cnt[k]  <= 0;
      end else begin
        if (rdy[k] && digest_valid) gap[k] <= cyc - last_done[k];
        if (dn[k]) begin
          dcnt[k]      <= dcnt[k] + 1;
          last_done[k] <= cyc;
        end
        if (snd[k]) begin
          if (!snt[k]) proto_err[k] <= proto_err[k] + 1;
          cap[k].push_back(bts[k]);
          held[k] <= bts[k];
          idle[k] <= 1'b0;
          cnt[k]  <= FRAME;
        end else if (!idle[k]) begin
          if (bts[k] != held[k]) stab_err[k] <= stab_err[k] + 1;
          if (cnt[k] <= 1) idle[k] <= 1'b1;
          cnt[k] <= cnt[k] - 1;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic chk_idle(input string nm);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_ready%0d", nm, k), 32'(rdy[k]), 1);
      check($sformatf("%s_send%0d", nm, k), 32'(snd[k]), 0);
      check($sformatf("%s_done%0d", nm, k), 32'(dn[k]), 0);
      check($sformatf("%s_byte%0d", nm, k), 32'(bts[k]), 0);
    end
  endtask

  task automatic add_exp(input logic [127:0] d);
    string s;
    s = $sformatf("%032h", d);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) exp_q[k].push_back(s[i]);
    exp_q[0].push_back(8'h0d);
    exp_q[0].push_back(8'h0a);
  endtask

  task automatic clear_q();
    for (int k = 0; k < 2; k++) begin
      cap[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic check_streams(input string nm);
    for (int k = 0; k < 2; k++) begin
      int bad;
      bad = -1;
      check($sformatf("%s_len%0d", nm, k), cap[k].size(), exp_q[k].size());
      for (int i = 0; i < cap[k].size() && i < exp_q[k].size(); i++)
        if (cap[k][i] !== exp_q[k][i] && bad < 0) bad = i;
      check($sformatf("%s_badidx%0d", nm, k), bad, -1);
      check($sformatf("%s_stable%0d", nm, k), stab_err[k], 0);
      check($sformatf("%s_proto%0d", nm, k), proto_err[k], 0);
    end
    clear_q();
  endtask

  task automatic wait_done(input int t0, input int t1);
    int n;
    n = 0;
    while ((dcnt[0] < t0 || dcnt[1] < t1) && n < 8000) begin
      @(negedge clock);
      n++;
    end
    check("done_timeout", 32'(dcnt[0] >= t0 && dcnt[1] >= t1), 1);
  endtask

  task automatic wait_chars(input int n);
    int c;
    c = 0;
    while (cap[0].size() < n && c < 8000) begin
      @(negedge clock);
      c++;
    end
    check("chars_timeout", 32'(cap[0].size() >= n), 1);
  endtask

  task automatic accept(input logic [127:0] d);
    @(negedge clock);
    digest       = d;
    digest_valid = 1'b1;
    @(negedge clock);
    digest_valid = 1'b0;
  endtask

  task automatic full_run(input string nm, input logic [127:0] d);
    int d0, d1;
    d0 = dcnt[0];
    d1 = dcnt[1];
    add_exp(d);
    accept(d);
    wait_done(d0 + 1, d1 + 1);
    repeat (3) @(negedge clock);
    check({nm, "_ready0"}, 32'(rdy[0]), 1);
    check({nm, "_ready1"}, 32'(rdy[1]), 1);
    check({nm, "_ndone0"}, dcnt[0], d0 + 1);
    check({nm, "_ndone1"}, dcnt[1], d1 + 1);
    check_streams(nm);
  endtask

  initial begin
    logic [127:0] a, b;
    int d0, d1;

    tbl = '{
      '{4'h0, 8'h30}, '{4'h1, 8'h31}, '{4'h2, 8'h32}, '{4'h3, 8'h33},
      '{4'h4, 8'h34}, '{4'h5, 8'h35}, '{4'h6, 8'h36}, '{4'h7, 8'h37},
      '{4'h8, 8'h38}, '{4'h9, 8'h39}, '{4'ha, 8'h61}, '{4'hb, 8'h62},
      '{4'hc, 8'h63}, '{4'hd, 8'h64}, '{4'he, 8'h65}, '{4'hf, 8'h66}
    };

    repeat (3) @(negedge clock);
    chk_idle("rst");
    reset = 1'b0;

    for (int t = 0; t < 16; t++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      a[127:124] = tbl[t].nib;
      accept(a);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("tbl%0d_char%0d", t, k), 32'(bts[k]), 32'(tbl[t].ch));
        check($sformatf("tbl%0d_send%0d", t, k), 32'(snd[k]), 1);
      end
      reset = 1'b1;
      @(negedge clock);
      chk_idle($sformatf("tbl%0d_rst", t));
      reset = 1'b0;
      clear_q();
    end

    full_run("seq", 128'h0123456789abcdeffedcba9876543210);
    full_run("ones", {128{1'b1}});
    for (int r = 0; r < 3; r++)
      full_run($sformatf("rand%0d", r),
               {$urandom, $urandom, $urandom, $urandom});

    a = 128'hdeadbeef_00112233_44556677_8899aabb;
    b = 128'hffffffff_ffffffff_00000000_00000000;
    d0 = dcnt[0];
    d1 = dcnt[1];
    add_exp(a);
    accept(a);
    wait_chars(6);
    @(negedge clock);
    digest       = b;
    digest_valid = 1'b1;
    @(negedge clock);
    digest_valid = 1'b0;
    wait_done(d0 + 1, d1 + 1);
    repeat (3) @(negedge clock);
    check("ign_ndone0", dcnt[0], d0 + 1);
    check("ign_ndone1", dcnt[1], d1 + 1);
    check_streams("ign");

    a = 128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978;
    d0 = dcnt[0];
    d1 = dcnt[1];
    add_exp(a);
    @(negedge clock);
    hold = 1'b1;
    accept(a);
    repeat (500) @(negedge clock);
    check("hold_sends0", cap[0].size(), 0);
    check("hold_sends1", cap[1].size(), 0);
    hold = 1'b0;
    wait_done(d0 + 1, d1 + 1);
    check_streams("hold");

    a = 128'hcafef00d_12345678_9abcdef0_0badc0de;
    d0 = dcnt[0];
    d1 = dcnt[1];
    accept(a);
    wait_chars(11);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_idle("midrst");
    reset = 1'b0;
    repeat (200) @(negedge clock);
    check("midrst_nodone0", dcnt[0], d0);
    check("midrst_nodone1", dcnt[1], d1);
    check("midrst_nosend0", cap[0].size(), 11);
    clear_q();
    full_run("fresh", 128'h89abcdef_01234567_fedcba98_76543210);

    a = 128'h00000000_11111111_22222222_33333333;
    b = 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd;
    d0 = dcnt[0];
    d1 = dcnt[1];
    add_exp(a);
    add_exp(b);
    @(negedge clock);
    digest       = a;
    digest_valid = 1'b1;
    @(negedge clock);
    digest = b;
    wait_done(d0 + 1, d1 + 1);
    @(posedge clock);
    @(negedge clock);
    digest_valid = 1'b0;
    wait_done(d0 + 2, d1 + 2);
    repeat (3) @(negedge clock);
    check("b2b_gap0", gap[0], 1);
    check("b2b_gap1", gap[1], 1);
    check("b2b_ndone0", dcnt[0], d0 + 2);
    check("b2b_ndone1", dcnt[1], d1 + 2);
    check_streams("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/digest_hex_tx.md
# digest_hex_tx

Upstream feeder for the `usart` transmitter. It latches a 128-bit MD5 digest and emits it as 32 lowercase ASCII hex characters, most-significant nibble first, optionally followed by CR LF. It drives the usart `bytetosend`/`send` inputs and paces itself on the usart `sent` status. This lets the digest core hand off a result in one cycle and return to hashing while the text drains over the serial line.

## Interface
- `NIBBLES`, 32: number of hex characters; digest width is 4*NIBBLES.
- `APPEND_CRLF`, 1: 1 appends 0x0D, 0x0A after the hex characters; 0 sends hex only.
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `digest`  in  4*NIBBLES  digest value; sampled only on acceptance.
- `digest_valid`  in  1  request to print `digest`.
- `ready`  out  1  high in IDLE; acceptance = `digest_valid & ready` at a rising edge.
- `done`  out  1  one-cycle pulse after the last character has fully left the usart.
- `bytetosend`  out  8  character to the usart; registered; held stable for the whole character time.
- `send`  out  1  one-cycle request to the usart.
- `sent`  in  1  usart idle status (high = idle, may accept a byte).

## Operation
- Registers:
  - `dig_q` (4*NIBBLES): latched digest.
  - `idx` (6 bits, counts 0..TOTAL-1): character index, where TOTAL = NIBBLES + 2*APPEND_CRLF.
  - `bytetosend`.
  - `state`: IDLE, SEND, WAIT_LOW, WAIT_HIGH.
- Character map:
  - Nibble 0-9 -> 0x30-0x39; nibble 10-15 -> 0x61-0x66.
  - Index i < NIBBLES selects `dig_q[4*(NIBBLES-i)-1 -: 4]`.
  - Index NIBBLES -> 0x0D; index NIBBLES+1 -> 0x0A.
- IDLE:
  - `ready=1`.
  - On `digest_valid`: `dig_q<=digest`, `idx<=0`, `bytetosend<=`char of the top nibble of `digest`, go SEND.
- SEND:
  - `send = (state==SEND) & sent`.
  - If `sent=1`, assert `send` and go WAIT_LOW.
  - If `sent=0`, hold with `send=0`. `send` must never be asserted while `sent=0`, because it would restart the usart bit timer.
- WAIT_LOW: wait for `sent=0`, i.e. the usart has taken the byte; then go WAIT_HIGH.
- WAIT_HIGH: wait for `sent=1`, i.e. start, 8 data and both stop bits are done.
  - If `idx==TOTAL-1`: pulse `done`, go IDLE.
  - Otherwise: `idx<=idx+1`, `bytetosend<=char(idx+1)`, go SEND.
- `bytetosend` changes only on acceptance and on WAIT_HIGH exit. The usart samples data bits throughout the frame, so stability is mandatory.
- `digest_valid` while not IDLE is ignored; no queuing, and `dig_q` is unchanged.
- `done` and a new acceptance cannot coincide, since `ready` is low in the `done` cycle. Acceptance is possible from the following cycle.

## Timing
- Reset values: `state=IDLE`, `ready=1`, `send=0`, `done=0`, `bytetosend=0x00`, `idx=0`, `dig_q=0`.
- Reset mid-transfer:
  - Immediate return to IDLE at the next edge.
  - The remaining characters are dropped.
  - No `done` pulse.
  - The usart is reset by the same `reset` and is idle.
- Acceptance at edge N: SEND is entered at N; `send` is high in cycle N+1 if `sent=1`.
- With the usart, `sent` falls one cycle after `send`. WAIT_LOW therefore lasts 1 cycle and WAIT_HIGH lasts about 11 bit periods: 11*138 cycles at 16 MHz / 115200 baud.
- Per-character overhead beyond the usart frame: 2 cycles (WAIT_HIGH exit -> SEND -> `send`).
- `done` rises in the cycle after the edge where WAIT_HIGH sees `sent=1` for the final character. It lasts exactly 1 cycle.
- A digest of 34 characters yields exactly 34 `send` pulses, with no duplicates and no gaps.

## Test plan
- Digest 0x0123456789abcdeffedcba9876543210, `APPEND_CRLF=1`, real usart at default parameters -> decoded tx stream is "0123456789abcdeffedcba9876543210" then 0x0D 0x0A; 34 `send` pulses; one `done`; `ready` returns high.
- Digest all-ones, `APPEND_CRLF=0` -> 32 bytes of 0x66, then `done`. `bytetosend` is checked constant from each `send` until the next WAIT_HIGH exit.
- `digest_valid` pulsed with a different value during character 5 -> ignored; output unchanged; exactly 34 characters.
- Behavioural usart model holding `sent=0` for 500 cycles after acceptance -> `send` stays 0 throughout; asserts once when `sent` rises; stream continues correctly.
- `reset` asserted during character 10 -> the next cycle shows `state=IDLE`, `send=0`, `bytetosend=0x00`, `ready=1`, no `done`. A fresh digest then prints completely from character 0.
- Back-to-back: `digest_valid` held high continuously with two successive values -> the second is accepted the cycle after `done`; two complete 34-character strings with no interleaving.
